// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: synchronises the serial line, finds the start bit, samples each
// bit at its centre and presents every good byte as a one-cycle strobe.
module uart_byte_receiver #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       uart_rx_done,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] TIMER_STEP = CNT_W'(1);

  if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
    $error("uart_byte_receiver: CLKS_PER_BIT must be at least 8");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [2:0]       idx, idx_nxt;
  logic             rx_p0, rx_p1;
  logic             rx_s;
  logic [7:0]       shift;
  logic             shift_en;
  logic             done_nxt;
  logic             ferr_nxt;

  // Stage p0/p1: two-flop synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= uart_rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // FSM state register together with the bit timer and bit index it steers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
        end
      end
      START: begin
        // A start bit must still be low half a bit later, otherwise it was a glitch
        if (timer == HALF_LAST) begin
          timer_nxt = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          timer_nxt = timer + TIMER_STEP;
        end
      end
      DATA: begin
        if (timer == BIT_LAST) begin
          timer_nxt = '0;
          if (idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          timer_nxt = timer + TIMER_STEP;
        end
      end
      STOP: begin
        // Leaving at mid-stop lets a back-to-back start edge be caught with no gap
        if (timer == BIT_LAST) begin
          timer_nxt = '0;
          state_nxt = rx_s ? IDLE : WAIT_IDLE;
        end else begin
          timer_nxt = timer + TIMER_STEP;
        end
      end
      WAIT_IDLE: begin
        timer_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    shift_en     = (state == DATA) && (timer == BIT_LAST);
    done_nxt     = (state == STOP) && (timer == BIT_LAST) && rx_s;
    ferr_nxt     = (state == STOP) && (timer == BIT_LAST) && !rx_s;
    uart_rx_busy = (state != IDLE);
  end

  // Assembly register: every bit is rewritten each frame, so no reset is needed
  always_ff @(posedge clk) begin
    if (shift_en) begin
      shift[idx] <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      uart_rx_done      <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_data      <= 8'h00;
    end else begin
      uart_rx_done      <= done_nxt;
      uart_rx_frame_err <= ferr_nxt;
      if (done_nxt) begin
        uart_rx_data <= shift;
      end
    end
  end

endmodule
